// File: rtl/logic_bit_monitor_pkg.sv
// Shared types and the 4-state to 2-state conversion helper for logic_bit_monitor.
package logic_bit_monitor_pkg;

  localparam int MAX_W      = 64;
  localparam int DATA_W_DEF = 4;
  localparam int TS_W_DEF   = 16;

  typedef enum logic [0:0] {S_FIRST, S_TRACK} state_e;

  typedef struct packed {
    logic                  xz;
    logic [DATA_W_DEF-1:0] data;
`ifdef LOGIC_BIT_MONITOR_TIMESTAMP_EN
    logic [TS_W_DEF-1:0]   ts;
`endif
  } evt_t;

  typedef struct packed {
    bit             xz;
    bit [MAX_W-1:0] data;
  } conv_t;

  // Callers zero-extend narrower buses; a 0 pad bit never hides an X in the parity.
  function automatic conv_t to_bit(input logic [MAX_W-1:0] v);
    conv_t r;
    r.xz   = ((^v) === 1'bx);
    r.data = v;
    return r;
  endfunction

endpackage

// File: rtl/logic_bit_monitor_evt_fifo.sv
// Registered event FIFO with occupancy count; no read bypass, pointers wrap modulo DEPTH.
module evt_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          doPush, doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign rdata_o = mem_q[rptr_q];
  assign level_o = count_q;

  always_comb begin
    count_d = count_q;
    if (doPush && !doPop) count_d = count_q + (AW+1)'(1);
    else if (doPop && !doPush) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wptr_q <= wptr_q + AW'(1);
      if (doPop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/logic_bit_monitor.sv
// Samples a 4-state bus, queues 2-state change events and counts X/Z samples.
// Optional LOGIC_BIT_MONITOR_TIMESTAMP_EN adds a cycle timestamp to every event.
module logic_bit_monitor
  import logic_bit_monitor_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
`ifdef LOGIC_BIT_MONITOR_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_en,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     clr_ovf,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [DATA_W-1:0]        evt_data,
  output logic                     evt_xz,
`ifdef LOGIC_BIT_MONITOR_TIMESTAMP_EN
  output logic [TS_W-1:0]          evt_ts,
`endif
  output logic [DATA_W-1:0]        cur_bit,
  output logic [CNT_W-1:0]         xz_count,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic              xz;
    logic [DATA_W-1:0] data;
`ifdef LOGIC_BIT_MONITOR_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
  } rec_t;

  conv_t             conv;
  logic [DATA_W-1:0] inBit;
  logic              inXz;
  logic              unused_conv;

  state_e            state_q;
  logic [DATA_W-1:0] lastBit_q;
  logic              lastXz_q;
  logic [CNT_W-1:0]  xzCnt_q, xzCnt_d;
  logic              ovf_q;
`ifdef LOGIC_BIT_MONITOR_TIMESTAMP_EN
  logic [TS_W-1:0]   ts_q;
`endif

  logic              push, pop, drop, full, empty;
  rec_t              wrec, rrec;
  logic [LW-1:0]     fifoLevel;

  always_comb begin
    conv        = to_bit(MAX_W'(in_data));
    inBit       = conv.data[DATA_W-1:0];
    inXz        = conv.xz;
    unused_conv = ^conv.data[MAX_W-1:DATA_W];
  end

  assign push = in_en && ((state_q == S_FIRST) || ({inBit, inXz} != {lastBit_q, lastXz_q}));
  assign pop  = !empty && evt_ready;
  assign drop = push && full && !pop;

  always_comb begin
    xzCnt_d = xzCnt_q;
    if (in_en && inXz && (xzCnt_q != {CNT_W{1'b1}})) xzCnt_d = xzCnt_q + CNT_W'(1);
  end

  // Idle cycles (in_en=0) leave the tracker untouched so the next sample compares against the last real one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FIRST;
      lastBit_q <= '0;
      lastXz_q  <= 1'b0;
      xzCnt_q   <= '0;
      ovf_q     <= 1'b0;
`ifdef LOGIC_BIT_MONITOR_TIMESTAMP_EN
      ts_q      <= '0;
`endif
    end else begin
      if (in_en) begin
        state_q   <= S_TRACK;
        lastBit_q <= inBit;
        lastXz_q  <= inXz;
      end
      xzCnt_q <= xzCnt_d;
      if (drop) ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
`ifdef LOGIC_BIT_MONITOR_TIMESTAMP_EN
      ts_q <= ts_q + TS_W'(1);
`endif
    end
  end

  always_comb begin
    wrec.xz   = inXz;
    wrec.data = inBit;
`ifdef LOGIC_BIT_MONITOR_TIMESTAMP_EN
    wrec.ts   = ts_q;
`endif
  end

  evt_fifo #(
    .W     ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wrec),
    .rdata_o (rrec),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifoLevel)
  );

  // Stale storage stays hidden behind evt_valid so an empty queue always reads as zero.
  assign evt_valid = !empty;
  assign evt_data  = evt_valid ? rrec.data : '0;
  assign evt_xz    = evt_valid ? rrec.xz : 1'b0;
`ifdef LOGIC_BIT_MONITOR_TIMESTAMP_EN
  assign evt_ts    = evt_valid ? rrec.ts : '0;
`endif
  assign cur_bit   = lastBit_q;
  assign xz_count  = xzCnt_q;
  assign overflow  = ovf_q;
  assign level     = fifoLevel;

endmodule

// File: tb/tb_logic_bit_monitor.sv
// Self-checking bench: queue-based event model compared every cycle plus directed literal pins.
module tb_logic_bit_monitor;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_en = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              clr_ovf = 1'b0;
  logic              evt_ready = 1'b0;
  logic              evt_valid;
  logic [DATA_W-1:0] evt_data;
  logic              evt_xz;
  logic [DATA_W-1:0] cur_bit;
  logic [CNT_W-1:0]  xz_count;
  logic              overflow;
  logic [LW-1:0]     level;
`ifdef LOGIC_BIT_MONITOR_TIMESTAMP_EN
  logic [15:0]       evt_ts;
`endif

  logic_bit_monitor #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .in_data   (in_data),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .evt_xz    (evt_xz),
`ifdef LOGIC_BIT_MONITOR_TIMESTAMP_EN
    .evt_ts    (evt_ts),
`endif
    .cur_bit   (cur_bit),
    .xz_count  (xz_count),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              xz;
  } ev_t;

  ev_t               q[$];
  ev_t               e;
  bit                first, modelOn, popNow, pushNow;
  logic [DATA_W-1:0] lastD;
  logic              lastX;
  int                xzCnt;
  bit                ovfM;
  int                checks = 0;
  int                errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sampled values become 2-state by "bit is exactly 1"; events live in a plain queue.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      first = 1; lastD = '0; lastX = 0; xzCnt = 0; ovfM = 0; modelOn = 1;
    end else if (modelOn) begin
      popNow  = (q.size() > 0) && evt_ready;
      pushNow = 0;
      if (in_en) begin
        for (int i = 0; i < DATA_W; i++) e.data[i] = (in_data[i] === 1'b1);
        e.xz    = $isunknown(in_data);
        pushNow = first || (e.data != lastD) || (e.xz != lastX);
        first   = 0;
        lastD   = e.data;
        lastX   = e.xz;
        if (e.xz && xzCnt < (1 << CNT_W) - 1) xzCnt++;
      end
      if (popNow) void'(q.pop_front());
      if (pushNow && q.size() == DEPTH) ovfM = 1;
      else begin
        if (pushNow) q.push_back(e);
        if (clr_ovf) ovfM = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("evt_valid", 32'(evt_valid), 32'(q.size() > 0));
      checkOutput("evt_data", 32'(evt_data), (q.size() > 0) ? 32'(q[0].data) : 32'd0);
      checkOutput("evt_xz", 32'(evt_xz), (q.size() > 0) ? 32'(q[0].xz) : 32'd0);
      checkOutput("cur_bit", 32'(cur_bit), 32'(lastD));
      checkOutput("xz_count", 32'(xz_count), 32'(xzCnt));
      checkOutput("overflow", 32'(overflow), 32'(ovfM));
      checkOutput("level", 32'(level), 32'(q.size()));
    end
  end

  task automatic applyStimulus(input logic r, input logic en, input logic [DATA_W-1:0] d,
                               input logic rdy, input logic clr);
    @(negedge clk);
    rst = r; in_en = en; in_data = d; evt_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] xPat;
  logic [DATA_W-1:0] v;

  initial begin
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_valid", 32'(evt_valid), 32'd0);
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_cur_bit", 32'(cur_bit), 32'd0);
    checkOutput("reset_xz_count", 32'(xz_count), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);

    applyStimulus(0, 1, 4'hB, 0, 0);
    checkOutput("first_valid", 32'(evt_valid), 32'd1);
    checkOutput("first_data", 32'(evt_data), 32'hB);
    checkOutput("first_xz", 32'(evt_xz), 32'd0);
    checkOutput("first_cur_bit", 32'(cur_bit), 32'hB);
    checkOutput("first_level", 32'(level), 32'd1);

    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 4'hB, 1, 0);
    checkOutput("hold_level", 32'(level), 32'd0);
    checkOutput("hold_xz_count", 32'(xz_count), 32'd0);

    xPat = 4'b1x0x;
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, xPat, 0, 0);
    checkOutput("xz_one_event", 32'(level), 32'd1);
    applyStimulus(0, 0, 0, 1, 0);

    for (int k = 1; k <= 5; k++) applyStimulus(0, 1, DATA_W'(k), 0, 0);
    checkOutput("fill_level", 32'(level), 32'd4);
    checkOutput("fill_overflow", 32'(overflow), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("drain_order", 32'(evt_data), 32'(k));
      applyStimulus(0, 0, 0, 1, 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("clr_overflow", 32'(overflow), 32'd0);
    checkOutput("drained_level", 32'(level), 32'd0);

    for (int k = 1; k <= 4; k++) applyStimulus(0, 1, DATA_W'(k), 0, 0);
    applyStimulus(0, 1, 4'h6, 1, 0);
    checkOutput("full_pushpop_level", 32'(level), 32'd4);
    checkOutput("full_pushpop_ovf", 32'(overflow), 32'd0);
    checkOutput("full_pushpop_head", 32'(evt_data), 32'd2);

    applyStimulus(0, 1, 4'hB, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("pre_reset_level", 32'(level), 32'd3);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("midreset_valid", 32'(evt_valid), 32'd0);
    checkOutput("midreset_level", 32'(level), 32'd0);
    applyStimulus(0, 1, 4'hB, 0, 0);
    checkOutput("after_reset_valid", 32'(evt_valid), 32'd1);
    checkOutput("after_reset_data", 32'(evt_data), 32'hB);

    v = 4'h0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) == 0) v = DATA_W'($urandom);
      xPat = v;
      if ($urandom_range(0, 5) == 0) xPat[$urandom_range(0, DATA_W - 1)] = 1'bx;
      applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), xPat,
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
